// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle radix-2 restoring divide controller for the EX stage.
// Runs DATA_W iterations for DIV/DIVU, holds the pipeline through stall_req_o
// while busy, and presents remainder/quotient as the HI/LO pair.
//
// Handshake: the issuing stage raises start_i and keeps it high (with stable
// operands) for as long as stall_req_o is high. done_o marks hi_o/lo_o as valid
// and stays high while start_i stays high. A new operation is accepted only
// after start_i has been low for at least one cycle. annul_i withdraws the
// request in any state: the operation is dropped, done_o does not rise for it,
// and hi_o/lo_o keep their previous values.
module div_seq_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              annul_i,
    output logic              stall_req_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rem;
    logic [DATA_W-1:0]  r_quo;
    logic [DATA_W-1:0]  r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;

    logic               w_start_ok;
    logic               w_stall;
    logic               w_last_iter;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [DATA_W-1:0]  w_a_mag;
    logic [DATA_W-1:0]  w_b_mag;
    logic [DATA_W:0]    w_shift;
    logic               w_ge;
    logic [DATA_W-1:0]  w_sub;
    logic [DATA_W-1:0]  w_rem_nxt;
    logic [DATA_W-1:0]  w_quo_nxt;
    logic [DATA_W-1:0]  w_q_fix;
    logic [DATA_W-1:0]  w_r_fix;

    assign w_start_ok  = start_i & ~annul_i;
    assign w_last_iter = (r_cnt == CNT_W'(DATA_W - 1));

    // Operand magnitudes: negative inputs are two's-complement negated for DIV.
    assign w_a_neg = signed_i & dividend_i[DATA_W-1];
    assign w_b_neg = signed_i & divisor_i[DATA_W-1];
    assign w_a_mag = w_a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign w_b_mag = w_b_neg ? (~divisor_i + 1'b1) : divisor_i;

    // One restoring step: shift {rem,quo} left, subtract when it fits.
    // The shifted remainder needs one extra bit; when w_ge holds, the true
    // difference is below 2**DATA_W so the low bits of the subtraction suffice.
    assign w_shift   = {r_rem, r_quo[DATA_W-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_sub     = w_shift[DATA_W-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_sub : w_shift[DATA_W-1:0];
    assign w_quo_nxt = {r_quo[DATA_W-2:0], w_ge};

    // Sign fixup applied to the final step's result as it is registered.
    assign w_q_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_r_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stall request; annul_i overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_stall     = 1'b1;
                    w_state_nxt = (divisor_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_ON: begin
                w_stall = 1'b1;
                if (w_last_iter) begin
                    w_state_nxt = S_END;
                end
            end
            S_BYZERO: begin
                w_stall     = 1'b1;
                w_state_nxt = S_END;
            end
            S_END: begin
                if (!start_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (annul_i) begin
            w_state_nxt = S_IDLE;
            w_stall     = 1'b0;
        end
    end

    // Datapath: operand latch, iteration, and result capture on entry to END.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_cnt <= '0;
                        r_rem <= '0;
                        if (divisor_i != '0) begin
                            r_quo   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end else begin
                            // Raw dividend becomes the remainder for divide-by-zero.
                            r_quo <= dividend_i;
                        end
                    end
                end
                S_ON: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_iter && !annul_i) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end
                end
                S_BYZERO: begin
                    if (!annul_i) begin
                        r_hi <= r_quo;
                        r_lo <= '1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_req_o = w_stall & rst;
    assign done_o      = (r_state == S_END);
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against an
// arithmetic reference model (plain / and % on operand magnitudes).
module tb_div_seq_ctrl;

  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_END  = 2'd3;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         annul_i;
  logic         stall_req_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic [1:0]   dbg_state_o;

  int pass_cnt;
  int total_cnt;
  logic [2*W-1:0] exp_q[$];

  div_seq_ctrl #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .annul_i     (annul_i),
    .stall_req_o (stall_req_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {remainder, quotient}.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] ma, mb, q, r;
    logic na, nb;
    if (b == 0) return {a, {W{1'b1}}};
    if (!sgn) return {a % b, a / b};
    na = a[W-1];
    nb = b[W-1];
    ma = na ? (0 - a) : a;
    mb = nb ? (0 - b) : b;
    q = ma / mb;
    r = ma % mb;
    if (na != nb) q = 0 - q;
    if (na) r = 0 - r;
    return {r, q};
  endfunction

  // Drives one request (start_i held) from a fresh negedge; returns the cycle
  // index of done_o, the number of stalled cycles before it, the stall value in
  // the done cycle and the result. Leaves start_i high.
  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int stall_cnt, output logic stall_at_done,
                        output logic [W-1:0] hi, output logic [W-1:0] lo);
    @(negedge clk);
    start_i = 1'b1;
    signed_i = sgn;
    dividend_i = a;
    divisor_i = b;
    lat = -1;
    stall_cnt = 0;
    stall_at_done = 1'bx;
    hi = 'x;
    lo = 'x;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done_o === 1'b1) begin
        lat = c;
        stall_at_done = stall_req_o;
        hi = hi_o;
        lo = lo_o;
        break;
      end
      if (stall_req_o === 1'b1) stall_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    int lat, sc;
    logic sd;
    logic [W-1:0] hi, lo;
    logic [2*W-1:0] exp;
    int exp_lat;
    exp_q.push_back(model(sgn, a, b));
    exp_lat = (b == 0) ? 2 : W + 1;
    do_div(sgn, a, b, lat, sc, sd, hi, lo);
    exp = exp_q.pop_front();
    total_cnt++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if ({hi, lo} !== exp)
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo,
               exp[2*W-1:W], exp[W-1:0]);
    else pass_cnt++;
    total_cnt++;
    if (sc !== exp_lat || sd !== 1'b0)
      $display("FAIL %s stall: got %0d stalled cycles, done-cycle stall %b want %0d, 0",
               name, sc, sd, exp_lat);
    else pass_cnt++;
    drop_start();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_i = 1'b0;
    signed_i = 1'b0;
    dividend_i = '0;
    divisor_i = '0;
    annul_i = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({done_o, stall_req_o, hi_o, lo_o, dbg_state_o} !== {2'b00, {2*W{1'b0}}, ST_IDLE})
      $display("FAIL reset: got done=%b stall=%b hi=%h lo=%h st=%0d want all 0",
               done_o, stall_req_o, hi_o, lo_o, dbg_state_o);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    check_op("divu_100_7", 1'b0, 32'd100, 32'd7);
  endtask

  task automatic test_signed();
    check_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_byzero();
    check_op("divu_by0", 1'b0, 32'h0000_1234, 32'd0);
    check_op("div_by0", 1'b1, 32'h8765_4321, 32'd0);
  endtask

  task automatic test_annul();
    logic [W-1:0] hi_prev, lo_prev;
    int done_seen;
    hi_prev = hi_o;
    lo_prev = lo_o;
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    #1;
    total_cnt++;
    if (stall_req_o !== 1'b0) $display("FAIL annul stall: got %b want 0", stall_req_o);
    else pass_cnt++;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    total_cnt++;
    if (dbg_state_o !== ST_IDLE) $display("FAIL annul state: got %0d want %0d", dbg_state_o, ST_IDLE);
    else pass_cnt++;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o !== 1'b0) done_seen++;
    end
    total_cnt++;
    if (done_seen != 0 || hi_o !== hi_prev || lo_o !== lo_prev)
      $display("FAIL annul hold: got done cycles %0d hi=%h lo=%h want 0 hi=%h lo=%h",
               done_seen, hi_o, lo_o, hi_prev, lo_prev);
    else pass_cnt++;
    check_op("divu_9_3", 1'b0, 32'd9, 32'd3);
  endtask

  task automatic test_reset_mid();
    int lat, sc;
    logic sd;
    logic [W-1:0] hi, lo;
    int end_bad;
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    dividend_i = 32'd55;
    divisor_i = 32'd5;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({done_o, stall_req_o, hi_o, lo_o, dbg_state_o} !== {2'b00, {2*W{1'b0}}, ST_IDLE})
      $display("FAIL reset_mid: got done=%b stall=%b hi=%h lo=%h st=%0d want all 0",
               done_o, stall_req_o, hi_o, lo_o, dbg_state_o);
    else pass_cnt++;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd100, 32'd7, lat, sc, sd, hi, lo);
    total_cnt++;
    if (lat !== W + 1 || hi !== 32'd2 || lo !== 32'd14)
      $display("FAIL post_reset div: got lat=%0d hi=%h lo=%h want %0d 2 14", lat, hi, lo, W + 1);
    else pass_cnt++;
    end_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o !== 1'b1 || dbg_state_o !== ST_END) end_bad++;
    end
    total_cnt++;
    if (end_bad != 0) $display("FAIL end_hold: got %0d bad cycles want 0", end_bad);
    else pass_cnt++;
    drop_start();
    total_cnt++;
    if (dbg_state_o !== ST_IDLE || done_o !== 1'b0)
      $display("FAIL end_exit: got st=%0d done=%b want %0d 0", dbg_state_o, done_o, ST_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = W'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == 0 && $urandom_range(0, 1) == 1) b = 32'd1;
      sgn = 1'($urandom_range(0, 1));
      check_op("random", sgn, a, b);
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_byzero();
    test_annul();
    test_reset_mid();
    test_random();
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard: got %0d leftover entries want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
